// File: rtl/seg7_scan_display_if.sv
// Signal bundle between the CPU-side wrapper and the 7-segment scan driver.
// The master drives the display sources; the slave is the scan driver.
interface seg7_scan_display_if;
  logic [31:0] value_in;
  logic [31:0] pc_in;
  logic        sel_pc;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output value_in, pc_in, sel_pc, blank_lz,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  value_in, pc_in, sel_pc, blank_lz,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit hex scan driver for a common-anode 7-segment display.
// Source is snapshotted once per frame so a changing value never tears.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 50000
) (
  input logic                 Clk,
  input logic                 reset,
  seg7_scan_display_if.slave  disp
);

  localparam int              PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   TC = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          snap_pc_q, snap_pc_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          ft_q, ft_d;

  logic          scan_tick;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    scan_tick = (presc_q == TC);
    presc_d   = scan_tick ? '0 : presc_q + PW'(1);
    idx_d     = scan_tick ? idx_q + 2'd1 : idx_q;
    wrap_d    = scan_tick && (idx_q == 2'd3);
    snap_d    = snap_q;
    snap_pc_d = snap_pc_q;
    if (wrap_d) begin
      snap_d    = disp.sel_pc ? disp.pc_in[15:0] : disp.value_in[15:0];
      snap_pc_d = disp.sel_pc;
    end
    // frame_tick trails the load by one cycle so it lines up with digit 0 on an
    ft_d = wrap_q;

    nib = snap_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd1:    blank = disp.blank_lz && (snap_q[15:4] == 12'h000);
      2'd2:    blank = disp.blank_lz && (snap_q[15:8] == 8'h00);
      2'd3:    blank = disp.blank_lz && (snap_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase

    an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : hex7(nib);
    dp_d  = ~((idx_q == 2'd0) && snap_pc_q);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0000;
      snap_pc_q <= 1'b0;
      wrap_q    <= 1'b0;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      ft_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      snap_pc_q <= snap_pc_d;
      wrap_q    <= wrap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      ft_q      <= ft_d;
    end
  end

  assign disp.an         = an_q;
  assign disp.seg        = seg_q;
  assign disp.dp         = dp_q;
  assign disp.frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: two instances (divider 4 and 2) checked every
// cycle against a cycle-count reference model, plus literal frame expectations.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value_in = 32'hFFFF1234;
  logic [31:0] pc_in = 32'h0;
  logic        sel_pc = 1'b0;
  logic        blank_lz = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_display_if if4 ();
  seg7_scan_display_if if2 ();

  assign if4.value_in = value_in;
  assign if4.pc_in    = pc_in;
  assign if4.sel_pc   = sel_pc;
  assign if4.blank_lz = blank_lz;
  assign if2.value_in = value_in;
  assign if2.pc_in    = pc_in;
  assign if2.sel_pc   = sel_pc;
  assign if2.blank_lz = blank_lz;

  seg7_scan_display #(.REFRESH_DIV(4)) dut4 (.Clk(clk), .reset(rst_n), .disp(if4.slave));
  seg7_scan_display #(.REFRESH_DIV(2)) dut2 (.Clk(clk), .reset(rst_n), .disp(if2.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: n edges since reset release fixes digit index, snapshot
  // instants and frame ticks purely arithmetically.
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int unsigned n_m    [2];
  logic [15:0] snap_m [2];
  logic        spc_m  [2];
  logic [3:0]  ean_m  [2];
  logic [6:0]  eseg_m [2];
  logic        edp_m  [2];
  logic        eft_m  [2];

  always @(posedge clk or negedge rst_n) begin
    int dv, idx, nibv;
    logic [15:0] upper;
    logic blk;
    for (int j = 0; j < 2; j++) begin
      dv = (j == 0) ? 4 : 2;
      if (!rst_n) begin
        n_m[j] = 0; snap_m[j] = 16'h0; spc_m[j] = 1'b0;
        ean_m[j] = 4'hF; eseg_m[j] = 7'h7F; edp_m[j] = 1'b1; eft_m[j] = 1'b0;
      end else begin
        idx   = (int'(n_m[j]) / dv) % 4;
        upper = snap_m[j] >> (4 * idx);
        nibv  = int'(upper & 16'h000F);
        blk   = blank_lz && (idx > 0) && (upper == 16'h0);
        ean_m[j]  = blk ? 4'hF : (4'hF ^ (4'd1 << idx));
        eseg_m[j] = blk ? 7'h7F : hex_tab[nibv];
        edp_m[j]  = !(idx == 0 && spc_m[j]);
        eft_m[j]  = (n_m[j] > 0) && (n_m[j] % (4 * dv) == 0);
        n_m[j]++;
        if (n_m[j] % (4 * dv) == 0) begin
          snap_m[j] = sel_pc ? pc_in[15:0] : value_in[15:0];
          spc_m[j]  = sel_pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m4_an",  if4.an,         ean_m[0]);
    chk("m4_seg", if4.seg,        eseg_m[0]);
    chk("m4_dp",  if4.dp,         edp_m[0]);
    chk("m4_ft",  if4.frame_tick, eft_m[0]);
    chk("m2_an",  if2.an,         ean_m[1]);
    chk("m2_seg", if2.seg,        eseg_m[1]);
    chk("m2_dp",  if2.dp,         edp_m[1]);
    chk("m2_ft",  if2.frame_tick, eft_m[1]);
  end

  logic        pend_en = 1'b0;
  logic [31:0] pend_val, pend_pc;
  logic        pend_sel, pend_blank;

  task automatic set_pend(input logic [31:0] v, input logic [31:0] p, input logic s, input logic b);
    pend_val = v; pend_pc = p; pend_sel = s; pend_blank = b; pend_en = 1'b1;
  endtask

  // Waits for frame_tick on the divide-by-4 instance, then checks each digit;
  // pending input changes are applied mid-frame while digit 1 is lit.
  task automatic check_frame(input string nm, input int max_w, input logic [15:0] ean,
                             input logic [27:0] eseg, input logic [3:0] edp);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (if4.frame_tick !== 1'b1 && w < max_w);
    chk({nm, "_tick"}, if4.frame_tick, 1);
    for (int off = 0; off < 15; off++) begin
      if (off % 4 == 0) begin
        chk({nm, "_an"},  if4.an,  ean[4*(off/4) +: 4]);
        chk({nm, "_seg"}, if4.seg, eseg[7*(off/4) +: 7]);
        chk({nm, "_dp"},  if4.dp,  edp[off/4]);
      end
      if (off == 5 && pend_en) begin
        value_in = pend_val; pc_in = pend_pc; sel_pc = pend_sel; blank_lz = pend_blank;
        pend_en = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] v;

    repeat (3) @(negedge clk);
    chk("rst_an4", if4.an, 4'hF);
    chk("rst_seg4", if4.seg, 7'h7F);
    chk("rst_dp4", if4.dp, 1'b1);
    chk("rst_ft4", if4.frame_tick, 1'b0);
    rst_n = 1'b1;

    set_pend(32'h5678, 32'h0, 1'b0, 1'b0);
    check_frame("f1234", 40, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
    set_pend(32'h0050, 32'h0, 1'b0, 1'b1);
    check_frame("f5678", 1, 16'h7BDE, {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF);
    set_pend(32'h0, 32'h0, 1'b0, 1'b1);
    check_frame("f0050", 1, 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
    set_pend(32'h8000, 32'h0, 1'b0, 1'b1);
    check_frame("f0000", 1, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
    set_pend(32'h8000, 32'h00AC, 1'b1, 1'b0);
    check_frame("f8000", 1, 16'h7BDE, {7'h00, 7'h40, 7'h40, 7'h40}, 4'hF);
    set_pend(32'h8000, 32'h00AC, 1'b0, 1'b0);
    check_frame("fpc", 1, 16'h7BDE, {7'h40, 7'h40, 7'h08, 7'h46}, 4'hE);
    check_frame("fback", 1, 16'h7BDE, {7'h00, 7'h40, 7'h40, 7'h40}, 4'hF);

    // Asynchronous reset while digit 2 is on display.
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an4", if4.an, 4'hF);
    chk("arst_seg4", if4.seg, 7'h7F);
    chk("arst_dp4", if4.dp, 1'b1);
    chk("arst_ft4", if4.frame_tick, 1'b0);
    chk("arst_an2", if2.an, 4'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (if4.frame_tick !== 1'b1 && cnt < 40);
    chk("restart_tick_delay", cnt, 17);
    chk("restart_digit0", if4.an, 4'hE);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        v = $urandom();
        v[15:0] = v[15:0] >> (4 * $urandom_range(0, 4));
        value_in = v;
        pc_in = $urandom() >> (4 * $urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) sel_pc = ~sel_pc;
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
    end

    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (if2.frame_tick !== 1'b1 && cnt < 20);
    chk("div2_first_tick", if2.frame_tick, 1);
    for (int f = 0; f < 10; f++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (if2.frame_tick !== 1'b1 && cnt < 20);
      chk("div2_period", cnt, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
